// File: rtl/spi_pixel_bridge_pkg.sv
// spi_pixel_bridge_pkg: shared widths, FIFO depth default and FSM state type
// for the SPI pixel bridge and its interface.
package spi_pixel_bridge_pkg;

    localparam int MAX_PIXEL_BITS     = 24;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Occupancy counter width: one extra bit so "full" is distinguishable from "empty".
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_pixel_bridge_if.sv
// spi_pixel_bridge_if: pixel and result streams between the bridge and the pipeline.
//   pixel_o / pixel_valid_o / pixel_ready_i    : received pixels, bridge -> pipeline
//   result_i / result_valid_i / result_ready_o : processed words, pipeline -> bridge
//   master : bridge side    slave : pipeline side
interface spi_pixel_bridge_if
    import spi_pixel_bridge_pkg::*;
#(
    parameter int WORD_SIZE = MAX_PIXEL_BITS
);

    logic [WORD_SIZE-1:0] pixel_o;
    logic                 pixel_valid_o;
    logic                 pixel_ready_i;
    logic [WORD_SIZE-1:0] result_i;
    logic                 result_valid_i;
    logic                 result_ready_o;

    modport master (
        output pixel_o, pixel_valid_o, result_ready_o,
        input  pixel_ready_i, result_i, result_valid_i
    );

    modport slave (
        input  pixel_o, pixel_valid_o, result_ready_o,
        output pixel_ready_i, result_i, result_valid_i
    );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: width-parameterized two-flop synchronizer with per-bit reset value.
//   clk_i    : destination clock
//   nreset_i : asynchronous active-low reset, loads RESET_VAL
//   d_i      : asynchronous inputs
//   q_o      : synchronized outputs
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_pixel_bridge.sv
// spi_pixel_bridge: moves words between an SPI shifter (SCK domain) and a
// valid/ready pixel pipeline through small RX/TX FIFOs, with frame tracking.
//   clk_i, nreset_i      : system clock, asynchronous active-low reset
//   cs_i                 : SPI chip select (active-low, asynchronous)
//   data_rx_i            : word received by the shifter
//   rxtx_done_i          : shifter word-complete flag
//   data_tx_o            : next word for the shifter to transmit
//   frame_done_o         : one-cycle pulse at the end of a CS frame
//   word_count_o         : words received in the current/last frame (saturating)
//   overflow_o           : sticky, an RX word was dropped on a full FIFO
//   underflow_o          : sticky, a word was transmitted from an empty TX FIFO
//   bus                  : pixel/result streams (master modport)
module spi_pixel_bridge
    import spi_pixel_bridge_pkg::*;
#(
    parameter int WORD_SIZE  = MAX_PIXEL_BITS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 cs_i,
    input  logic [WORD_SIZE-1:0] data_rx_i,
    input  logic                 rxtx_done_i,
    output logic [WORD_SIZE-1:0] data_tx_o,
    output logic                 frame_done_o,
    output logic [15:0]          word_count_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    spi_pixel_bridge_if.master   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = cnt_bits(FIFO_DEPTH);

    logic [1:0] sync_s;
    logic       cs_s;
    logic       done_s;
    logic       cs_prev_q;
    logic       done_prev_q;
    logic       word_evt;
    logic       cs_fall;
    logic       cs_rise;
    logic       evt;
    logic       frame_start;

    state_t state_q;
    state_t state_d;

    logic [WORD_SIZE-1:0] rx_mem [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                 rx_empty, rx_full, rx_push, rx_pop;
    logic                 tx_empty, tx_full, tx_push, tx_pop;

    logic [WORD_SIZE-1:0] data_tx_q, data_tx_d;
    logic [15:0]          word_count_q, word_count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    // Bit 1 carries cs (idles high), bit 0 carries done (idles low).
    sync_2ff #(
        .WIDTH     (2),
        .RESET_VAL (2'b10)
    ) u_sync (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .d_i      ({cs_i, rxtx_done_i}),
        .q_o      (sync_s)
    );

    assign cs_s     = sync_s[1];
    assign done_s   = sync_s[0];
    assign word_evt = done_s & ~done_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign evt      = word_evt && (state_q == ST_ACTIVE);

    always_comb begin
        state_d      = state_q;
        frame_start  = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d      = ST_IDLE;
                    frame_done_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_empty = rx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == CW'(FIFO_DEPTH);
    assign rx_pop   = ~rx_empty & bus.pixel_ready_i;
    // A full FIFO still accepts the word when the head leaves in the same cycle.
    assign rx_push  = evt & (~rx_full | rx_pop);

    assign tx_empty = tx_cnt_q == '0;
    assign tx_full  = tx_cnt_q == CW'(FIFO_DEPTH);
    assign tx_push  = bus.result_valid_i & ~tx_full;
    assign tx_pop   = evt & ~tx_empty;

    assign bus.pixel_valid_o  = ~rx_empty;
    assign bus.pixel_o        = rx_empty ? '0 : rx_mem[rx_rd_q];
    assign bus.result_ready_o = ~tx_full;

    always_comb begin
        rx_wr_d      = rx_wr_q + AW'(rx_push);
        rx_rd_d      = rx_rd_q + AW'(rx_pop);
        rx_cnt_d     = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        tx_wr_d      = tx_wr_q + AW'(tx_push);
        tx_rd_d      = tx_rd_q + AW'(tx_pop);
        tx_cnt_d     = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        data_tx_d    = !evt ? data_tx_q : tx_empty ? '0 : tx_mem[tx_rd_q];
        overflow_d   = overflow_q | (evt & rx_full & ~rx_pop);
        underflow_d  = underflow_q | (evt & tx_empty);
        word_count_d = frame_start ? 16'd0 :
                       (evt && word_count_q != 16'hFFFF) ? word_count_q + 16'd1 : word_count_q;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= ST_IDLE;
            cs_prev_q    <= 1'b1;
            done_prev_q  <= 1'b0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_cnt_q     <= '0;
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_cnt_q     <= '0;
            data_tx_q    <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_prev_q    <= cs_s;
            done_prev_q  <= done_s;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            tx_cnt_q     <= tx_cnt_d;
            data_tx_q    <= data_tx_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset; the counts alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_q] <= data_rx_i;
        if (tx_push) tx_mem[tx_wr_q] <= bus.result_i;
    end

    assign data_tx_o    = data_tx_q;
    assign word_count_o = word_count_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_spi_pixel_bridge.sv
// tb_spi_pixel_bridge: scoreboard bench for the SPI pixel bridge with a queue-based reference model.
module tb_spi_pixel_bridge;
    import spi_pixel_bridge_pkg::*;

    localparam int W = MAX_PIXEL_BITS;
    localparam int D = DEFAULT_FIFO_DEPTH;

    logic         clk_i = 1'b0;
    logic         nreset_i = 1'b0;
    logic         cs_i = 1'b1;
    logic         rxtx_done_i = 1'b0;
    logic [W-1:0] data_rx_i = '0;
    logic [W-1:0] data_tx_o;
    logic         frame_done_o, overflow_o, underflow_o;
    logic [15:0]  word_count_o;

    spi_pixel_bridge_if #(.WORD_SIZE(W)) bus ();

    spi_pixel_bridge #(.WORD_SIZE(W), .FIFO_DEPTH(D)) dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .cs_i         (cs_i),
        .data_rx_i    (data_rx_i),
        .rxtx_done_i  (rxtx_done_i),
        .data_tx_o    (data_tx_o),
        .frame_done_o (frame_done_o),
        .word_count_o (word_count_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o),
        .bus          (bus)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cycles = 0;
    int last_pop_cyc = -1;
    int done_cyc = 0;

    // Reference model state
    logic [W-1:0] exp_q [$];
    logic [W-1:0] txq [$];
    logic [W-1:0] last_tx = '0;
    int           rx_occ = 0;
    int           wc_m = 0;
    bit           ovf_m = 0;
    bit           unf_m = 0;
    bit           in_frame = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: every accepted pixel is compared with the oldest expected word.
    always @(negedge clk_i) begin
        if (nreset_i) begin
            if (bus.pixel_valid_o) valid_cycles++;
            if (bus.pixel_valid_o && bus.pixel_ready_i) begin
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_unexpected: got %0h, none expected", bus.pixel_o);
                end else begin
                    check("pixel", bus.pixel_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_data_tx", data_tx_o, 0);
        check("rst_pixel", bus.pixel_o, 0);
        check("rst_pixel_valid", bus.pixel_valid_o, 0);
        check("rst_result_ready", bus.result_ready_o, 1);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_word_count", word_count_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_underflow", underflow_o, 0);
    endtask

    task automatic start_frame();
        cs_i = 1'b0;
        tick(4);
        in_frame = 1;
        wc_m = 0;
        check("wc_clear", word_count_o, 0);
    endtask

    task automatic end_frame();
        int pulses;
        pulses = 0;
        cs_i = 1'b1;
        repeat (8) begin
            @(negedge clk_i);
            if (frame_done_o) pulses++;
        end
        check("frame_done_pulses", pulses, 1);
        check("wc_hold", word_count_o, wc_m);
        in_frame = 0;
        tick(1);
    endtask

    // late: raise pixel_ready_i exactly in the word_evt cycle (push and pop together).
    task automatic send_word(input logic [W-1:0] data, input bit late);
        logic [W-1:0] exp_tx;
        exp_tx = last_tx;
        if (in_frame) begin
            if (wc_m < 16'hFFFF) wc_m++;
            if (txq.size() != 0) exp_tx = txq.pop_front();
            else begin
                exp_tx = '0;
                unf_m = 1;
            end
            if (late || bus.pixel_ready_i) exp_q.push_back(data);
            else if (rx_occ < D) begin
                exp_q.push_back(data);
                rx_occ++;
            end else ovf_m = 1;
        end
        last_tx = exp_tx;
        data_rx_i = data;
        rxtx_done_i = 1'b1;
        done_cyc = cyc;
        if (late) begin
            tick(2);
            bus.pixel_ready_i = 1'b1;
            tick(2);
        end else tick(4);
        rxtx_done_i = 1'b0;
        tick(4);
        check("data_tx", data_tx_o, exp_tx);
        check("word_count", word_count_o, wc_m);
        check("overflow", overflow_o, ovf_m);
        check("underflow", underflow_o, unf_m);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.pixel_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        tick(1);
        rx_occ = 0;
        check("drained_valid", bus.pixel_valid_o, 0);
    endtask

    task automatic push_result(input logic [W-1:0] v);
        int n;
        n = 0;
        bus.result_i = v;
        bus.result_valid_i = 1'b1;
        while (!bus.result_ready_o && n < 20) begin
            tick(1);
            n++;
        end
        if (!bus.result_ready_o) fail_now("result_ready_timeout");
        else begin
            tick(1);
            txq.push_back(v);
        end
        bus.result_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vc0;
        bus.pixel_ready_i = 1'b0;
        bus.result_valid_i = 1'b0;
        bus.result_i = '0;
        tick(3);
        @(negedge clk_i);
        check_reset_vals();
        nreset_i = 1'b1;
        tick(3);

        // TX path: two results then three words; third word underflows.
        start_frame();
        bus.pixel_ready_i = 1'b1;
        push_result(24'h000011);
        push_result(24'h000022);
        send_word(24'h111111, 0);
        send_word(24'h222222, 0);
        send_word(24'h333333, 0);
        end_frame();

        // Single word latency and one-cycle valid.
        start_frame();
        vc0 = valid_cycles;
        last_pop_cyc = -1;
        send_word(24'hA5C3F0, 0);
        check("latency_ok", (last_pop_cyc >= done_cyc) && (last_pop_cyc - done_cyc <= 4), 1);
        check("valid_one_cycle", valid_cycles - vc0, 1);

        // Full FIFO with a pop in the word_evt cycle: no drop, no overflow.
        bus.pixel_ready_i = 1'b0;
        for (int i = 0; i < D; i++) send_word(W'(24'h100 + i), 0);
        send_word(24'h0ABCDE, 1);
        drain();
        end_frame();

        // Word while idle is ignored.
        send_word(24'h777777, 0);

        // Overflow: five words, fifth dropped.
        start_frame();
        bus.pixel_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send_word(W'(24'h500 + i), 0);
        check("ovf_wc5", word_count_o, 5);
        drain();
        end_frame();

        // Reset mid-frame with two words queued.
        start_frame();
        bus.pixel_ready_i = 1'b0;
        send_word(24'h0C0FFE, 0);
        send_word(24'h0BEEF0, 0);
        nreset_i = 1'b0;
        #2;
        exp_q.delete();
        txq.delete();
        ovf_m = 0;
        unf_m = 0;
        rx_occ = 0;
        wc_m = 0;
        in_frame = 0;
        last_tx = '0;
        @(negedge clk_i);
        check_reset_vals();
        cs_i = 1'b1;
        tick(2);
        nreset_i = 1'b1;
        tick(10);
        check("post_reset_valid", bus.pixel_valid_o, 0);

        // Randomized frames against the model.
        for (int it = 0; it < 20; it++) begin
            int nr;
            int k;
            start_frame();
            nr = $urandom_range(0, D - txq.size());
            for (int j = 0; j < nr; j++) push_result(W'($urandom));
            bus.pixel_ready_i = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) send_word(W'($urandom), 0);
            drain();
            end_frame();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_pixel_bridge.md
SPI_PIXEL_BRIDGE -- requirements
Module: spi_pixel_bridge

Interface
REQ-001 Parameter WORD_SIZE, default MAX_PIXEL_BITS (24), SPI word and pixel width.
REQ-002 Parameter FIFO_DEPTH, default 4, entries in each of the RX and TX FIFOs; power of two, at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  system clock.
REQ-005 nreset_i  input  1  asynchronous active-low reset.
REQ-006 cs_i  input  1  SPI chip select, active-low, asynchronous to clk_i.
REQ-007 data_rx_i  input  WORD_SIZE  received word from the SPI shifter, SCK domain.
REQ-008 rxtx_done_i  input  1  word-complete flag from the SPI shifter, SCK domain.
REQ-009 data_tx_o  output  WORD_SIZE  next word for the SPI shifter to transmit.
REQ-010 pixel_o  output  WORD_SIZE  received pixel toward the processing pipeline.
REQ-011 pixel_valid_o / pixel_ready_i  output / input  1  valid/ready handshake for pixel_o.
REQ-012 result_i  input  WORD_SIZE  processed word to be sent back over SPI.
REQ-013 result_valid_i / result_ready_o  input / output  1  valid/ready handshake for result_i.
REQ-014 frame_done_o  output  1  one-cycle pulse when a CS frame ends.
REQ-015 word_count_o  output  16  words received in the current or last frame.
REQ-016 overflow_o / underflow_o  output  1  sticky RX-drop and TX-empty error flags.

Function
REQ-017 rxtx_done_i and cs_i SHALL each pass through a 2-flop synchronizer. A rising-edge detect on the synchronized done SHALL create a one-cycle word_evt.
REQ-018 On word_evt, data_rx_i SHALL be sampled into the RX FIFO in the same cycle. Timing constraint: SCK period >= 4 clk_i periods, so data_rx_i is stable at sampling.
REQ-019 RX FIFO behaviour:
- pixel_valid_o = not empty; pixel_o = head entry.
- A transfer occurs when pixel_valid_o && pixel_ready_i.
- Simultaneous push and pop SHALL be legal even when full.
REQ-020 If the RX FIFO is full on word_evt with no pop in that cycle:
- the word SHALL be dropped;
- overflow_o SHALL set and hold until reset.
REQ-021 TX FIFO behaviour:
- result_ready_o = not full; a push occurs on result_valid_i && result_ready_o.
- Simultaneous push and pop SHALL be legal.
REQ-022 On word_evt, data_tx_o SHALL load the TX FIFO head (pop). If the TX FIFO is empty, data_tx_o SHALL load 0 and underflow_o SHALL set sticky. data_tx_o SHALL otherwise hold.
REQ-023 FSM states IDLE and ACTIVE:
- IDLE->ACTIVE on synchronized cs falling; word_count_o cleared to 0 in that cycle.
- ACTIVE->IDLE on synchronized cs rising; frame_done_o pulses for exactly 1 cycle.
REQ-024 word_count_o SHALL increment on each word_evt in ACTIVE, including dropped words. It SHALL saturate at 16'hFFFF and hold its value in IDLE.
REQ-025 word_evt in IDLE SHALL be ignored (no push, no pop, no count).
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL use a log2(FIFO_DEPTH)+1-bit count.

Reset
REQ-027 When nreset_i is low:
- both FIFOs empty;
- FSM in IDLE;
- synchronizer flops at their idle values: cs=1, done=0.
REQ-028 Output reset values: data_tx_o=0, pixel_o=0, pixel_valid_o=0, result_ready_o=1, frame_done_o=0, word_count_o=0, overflow_o=0, underflow_o=0.
REQ-029 Reset asserted mid-frame SHALL discard FIFO contents. After release, no word_evt SHALL occur until a fresh done edge.

Structure
REQ-030 MAX_PIXEL_BITS and the FIFO_DEPTH default SHALL live in the shared parameters package. The FSM state enum SHALL be a typedef in the same package.
REQ-031 The block SHALL instantiate one sub-module, sync_2ff (width-parameterized synchronizer), for cs_i and rxtx_done_i. The two FIFOs SHALL be inline.

Verification
REQ-032 Single word: cs low, send 0xA5C3F0, pixel_ready_i=1 -> pixel_o=0xA5C3F0 with pixel_valid_o high for 1 cycle, within 4 clk after the done edge; word_count_o=1.
REQ-033 Overflow: pixel_ready_i=0, send 5 words with FIFO_DEPTH=4 -> first 4 words retained in order, 5th dropped, overflow_o=1, word_count_o=5.
REQ-034 TX path: push results 0x000011 and 0x000022, then 3 SPI words -> data_tx_o loads 0x11, then 0x22, then 0; underflow_o=1 after the third.
REQ-035 Frame end: cs rises after 3 words -> frame_done_o pulses for exactly 1 cycle, FSM returns to IDLE, word_count_o holds 3; a new cs fall clears it to 0.
REQ-036 Simultaneous events: RX FIFO full with pixel_ready_i=1 on the word_evt cycle -> push and pop both occur, occupancy stays 4, overflow_o stays 0.
REQ-037 Reset mid-frame: assert nreset_i with 2 words queued -> all outputs at REQ-028 values; after release, pixel_valid_o stays 0 until a new word arrives.
